servo_scan_sequencer: RTL and testbench
=======================================

# servo_scan_sequencer

Sequences the X/Y tracking-servo pair through an automatic raster scan. It zeroes both axes, sweeps X forward and reverse for a programmed number of PWM periods, and steps Y down between rows. It then issues return-to-zero to both axes and reports completion. It sits between the APB register front end and the two servo channels, and drives their one-cycle command strobes in place of direct software writes. The Y lower kill switch ends a scan early.

## Interface
- PERIOD, 2000000: PWM period in PCLK cycles (20 ms at 100 MHz). Must match the servo channels. Use 10 in simulation.
- PCLK  in  1  clock
- PRESET  in  1  synchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  one-cycle request; sampled in any non-IDLE state
- rows  in  8  number of X sweeps; captured at start
- x_periods  in  16  PWM periods per X sweep; captured at start
- y_periods  in  16  PWM periods per Y step; captured at start
- ret_periods  in  16  PWM periods allowed for return-to-zero; captured at start
- stop_y  in  2  kill switches, active-low: [1] upper, [0] lower
- x_zero, x_fwd, x_rev, x_neu, x_rtz  out  1 each  X servo command strobes
- y_zero, y_fwd, y_neu, y_rtz  out  1 each  Y servo command strobes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal or kill-terminated completion
- err  out  1  one-cycle pulse when start is rejected
- killed  out  1  sticky; set by a kill termination, cleared at the next accepted start
- row  out  8  index of the current row, 0-based

## Operation
- States: IDLE, ZERO, SWEEP, STEP, RETURN.
- Outputs are registered. Each command strobe is high for exactly one cycle: the first cycle after entering a state.
- Period counter: 32 bits. Cleared on every state entry. A tick fires in the cycle the counter equals PERIOD-1. A dwell of N periods therefore lasts exactly N*PERIOD cycles.
- IDLE + start:
  - If rows==0 or x_periods==0: pulse err and stay in IDLE.
  - Otherwise: capture the inputs, set row=0, clear killed, go to ZERO.
- ZERO: strobe x_zero and y_zero. After 1 tick, go to SWEEP with dir=forward.
- SWEEP: strobe x_fwd if dir=forward, else x_rev. After x_periods ticks:
  - If row==rows-1: go to RETURN.
  - Otherwise: go to STEP.
- STEP: strobe x_neu and y_fwd (forward moves Y down). After y_periods ticks: row++, toggle dir, go to SWEEP.
- Kill:
  - In STEP, stop_y[0]==0 in any cycle: next cycle strobe y_neu, set killed, go to RETURN.
  - stop_y[0]==0 is also checked on entry to STEP. If low at entry, y_fwd is suppressed and the kill takes effect immediately.
  - stop_y[1] is ignored: the sequencer never drives Y reverse.
- RETURN: strobe x_rtz and y_rtz. After ret_periods ticks (0 is treated as 1): strobe x_neu and y_neu, pulse done, go to IDLE.
- Abort: from any non-IDLE state, next cycle strobe x_neu and y_neu, go to IDLE. No done pulse.
- Priority: PRESET > abort > kill > tick.
- start while busy: ignored, no err.
- Reset: state IDLE, all strobes/done/err/killed/busy = 0, row = 0, period counter = 0.

## Timing
- start is sampled at edge t. busy=1 and x_zero=y_zero=1 in cycle t+1.
- X sweep 0 strobes at t+1+PERIOD.
- Normal scan latency, start to done:
  - 1 + PERIOD·(1 + rows·x_periods + (rows-1)·y_periods + ret_periods) cycles.
  - done coincides with the final x_neu/y_neu strobes. busy falls in the same cycle done is high.
- Kill: stop_y[0] low at edge k gives y_neu at k+1, then x_rtz/y_rtz at k+2.
- Abort: abort at edge a gives x_neu/y_neu and busy=0 at a+1.
- A strobe never coincides with another strobe of the same axis, except the single final neutral pair.
- row is updated in the same cycle as the SWEEP entry strobe.

## Test plan
- PERIOD=10, rows=3, x=2, y=1, ret=4, stop_y=2'b11, start:
  - Strobe order: zero, x_fwd, x_neu/y_fwd, x_rev, x_neu/y_fwd, x_fwd, rtz, neu.
  - done at cycle 1+10·(1+6+2+4)=131. row sequence 0,1,2.
- Same configuration, stop_y[0] driven low mid-way through the first STEP:
  - y_neu next cycle, then x_rtz/y_rtz. killed=1, done after 4 periods, row stays 0.
- abort during the second SWEEP: x_neu/y_neu one cycle later, busy=0, no done. A following start is accepted normally.
- start with rows=0, and separately with x_periods=0: err pulse, busy stays 0, no strobes.
- PRESET asserted mid-STEP: next cycle all outputs 0, IDLE, no strobes. start is accepted on the cycle after PRESET is released.
- start re-asserted while busy, and abort asserted in IDLE: both ignored, and scan timing is identical to the first scenario.

Source files
------------

// File: rtl/servo_scan_sequencer.sv
// Raster-scan sequencer for the X/Y tracking-servo pair: zero, serpentine X sweeps with
// Y steps between rows, then return-to-zero. Drives one-cycle command strobes to both channels.
module servo_scan_sequencer #(
  parameter int PERIOD = 2000000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  rows,
  input  logic [15:0] x_periods,
  input  logic [15:0] y_periods,
  input  logic [15:0] ret_periods,
  input  logic [1:0]  stop_y,
  output logic        x_zero,
  output logic        x_fwd,
  output logic        x_rev,
  output logic        x_neu,
  output logic        x_rtz,
  output logic        y_zero,
  output logic        y_fwd,
  output logic        y_neu,
  output logic        y_rtz,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        killed,
  output logic [7:0]  row
);

  typedef enum logic [2:0] {IDLE, ZERO, SWEEP, STEP, RETURN} state_t;

  localparam logic [31:0] LAST = 32'(PERIOD - 1);

  state_t      state, state_n;
  logic [31:0] cnt;
  logic [15:0] pcnt;
  logic [7:0]  rows_c;
  logic [15:0] xp_c, yp_c, rp_c;
  logic        dir, dir_n;
  logic        kwait, kwait_n;
  logic        enter, cap, tick;
  logic        x_zero_n, x_fwd_n, x_rev_n, x_neu_n, x_rtz_n;
  logic        y_zero_n, y_fwd_n, y_neu_n, y_rtz_n;
  logic        done_n, err_n, killed_n;
  logic [7:0]  row_n;
  logic        stop_upper_unused;

  // The sequencer never drives Y in reverse, so the upper kill switch has no effect here.
  assign stop_upper_unused = stop_y[1];

  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  assign tick = (cnt == LAST);

  always_comb begin
    state_n  = state;
    enter    = 1'b0;
    cap      = 1'b0;
    dir_n    = dir;
    kwait_n  = kwait;
    row_n    = row;
    killed_n = killed;
    done_n   = 1'b0;
    err_n    = 1'b0;
    x_zero_n = 1'b0; x_fwd_n = 1'b0; x_rev_n = 1'b0; x_neu_n = 1'b0; x_rtz_n = 1'b0;
    y_zero_n = 1'b0; y_fwd_n = 1'b0; y_neu_n = 1'b0; y_rtz_n = 1'b0;
    if (state != IDLE && abort) begin
      state_n = IDLE;
      kwait_n = 1'b0;
      x_neu_n = 1'b1;
      y_neu_n = 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (rows == 8'd0 || x_periods == 16'd0) begin
            err_n = 1'b1;
          end else begin
            state_n  = ZERO;
            enter    = 1'b1;
            cap      = 1'b1;
            row_n    = 8'd0;
            killed_n = 1'b0;
            x_zero_n = 1'b1;
            y_zero_n = 1'b1;
          end
        end
        ZERO: if (tick) begin
          state_n = SWEEP;
          enter   = 1'b1;
          dir_n   = 1'b0;
          x_fwd_n = 1'b1;
        end
        SWEEP: if (tick && pcnt == xp_c - 16'd1) begin
          enter = 1'b1;
          if (row == rows_c - 8'd1) begin
            state_n = RETURN;
            x_rtz_n = 1'b1;
            y_rtz_n = 1'b1;
          end else begin
            x_neu_n = 1'b1;
            // A lower kill already asserted at STEP entry replaces y_fwd with y_neu.
            if (!stop_y[0]) begin
              state_n  = RETURN;
              kwait_n  = 1'b1;
              killed_n = 1'b1;
              y_neu_n  = 1'b1;
            end else begin
              state_n = STEP;
              y_fwd_n = 1'b1;
            end
          end
        end
        STEP: begin
          if (!stop_y[0]) begin
            state_n  = RETURN;
            enter    = 1'b1;
            kwait_n  = 1'b1;
            killed_n = 1'b1;
            y_neu_n  = 1'b1;
          end else if (tick && pcnt == yp_c - 16'd1) begin
            state_n = SWEEP;
            enter   = 1'b1;
            row_n   = row + 8'd1;
            dir_n   = ~dir;
            x_fwd_n = dir;
            x_rev_n = ~dir;
          end
        end
        RETURN: begin
          // After a kill, RETURN is really entered one cycle later, once y_neu has gone out.
          if (kwait) begin
            kwait_n = 1'b0;
            enter   = 1'b1;
            x_rtz_n = 1'b1;
            y_rtz_n = 1'b1;
          end else if (tick && pcnt == rp_c - 16'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
            x_neu_n = 1'b1;
            y_neu_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state  <= IDLE;
      cnt    <= 32'd0;
      pcnt   <= 16'd0;
      dir    <= 1'b0;
      kwait  <= 1'b0;
      x_zero <= 1'b0; x_fwd <= 1'b0; x_rev <= 1'b0; x_neu <= 1'b0; x_rtz <= 1'b0;
      y_zero <= 1'b0; y_fwd <= 1'b0; y_neu <= 1'b0; y_rtz <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      killed <= 1'b0;
      row    <= 8'd0;
    end else begin
      state <= state_n;
      if (enter || tick) begin
        cnt <= 32'd0;
      end else begin
        cnt <= cnt + 32'd1;
      end
      if (enter) begin
        pcnt <= 16'd0;
      end else if (tick) begin
        pcnt <= pcnt + 16'd1;
      end
      dir    <= dir_n;
      kwait  <= kwait_n;
      x_zero <= x_zero_n; x_fwd <= x_fwd_n; x_rev <= x_rev_n; x_neu <= x_neu_n; x_rtz <= x_rtz_n;
      y_zero <= y_zero_n; y_fwd <= y_fwd_n; y_neu <= y_neu_n; y_rtz <= y_rtz_n;
      busy   <= (state_n != IDLE);
      done   <= done_n;
      err    <= err_n;
      killed <= killed_n;
      row    <= row_n;
    end
  end

  // Scan configuration is data: held from the accepted start, no reset needed.
  always_ff @(posedge PCLK) begin
    if (cap) begin
      rows_c <= rows;
      xp_c   <= x_periods;
      yp_c   <= at_least_one(y_periods);
      rp_c   <= at_least_one(ret_periods);
    end
  end

endmodule

// File: tb/tb_servo_scan_sequencer.sv
// Directed bench for servo_scan_sequencer with PERIOD=10: cycle-by-cycle comparison of all
// outputs against hand-derived timelines for normal, kill, abort, reset and rejected starts.
module tb_servo_scan_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET, start, abort;
  logic [7:0]  rows;
  logic [15:0] x_periods, y_periods, ret_periods;
  logic [1:0]  stop_y;
  logic        x_zero, x_fwd, x_rev, x_neu, x_rtz;
  logic        y_zero, y_fwd, y_neu, y_rtz;
  logic        busy, done, err, killed;
  logic [7:0]  row;
  logic [20:0] obs;
  int          checks = 0;
  int          failures = 0;

  servo_scan_sequencer #(.PERIOD(10)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .abort(abort), .rows(rows),
    .x_periods(x_periods), .y_periods(y_periods), .ret_periods(ret_periods), .stop_y(stop_y),
    .x_zero(x_zero), .x_fwd(x_fwd), .x_rev(x_rev), .x_neu(x_neu), .x_rtz(x_rtz),
    .y_zero(y_zero), .y_fwd(y_fwd), .y_neu(y_neu), .y_rtz(y_rtz),
    .busy(busy), .done(done), .err(err), .killed(killed), .row(row)
  );

  always #5 PCLK = ~PCLK;

  // {x_zero,x_fwd,x_rev,x_neu,x_rtz, y_zero,y_fwd,y_neu,y_rtz, busy,done,err,killed, row}
  assign obs = {x_zero, x_fwd, x_rev, x_neu, x_rtz, y_zero, y_fwd, y_neu, y_rtz,
                busy, done, err, killed, row};

  // c counts edges after the start-sampling edge (c=0 is the cycle right after it).
  // scen 0 normal, 1 kill at c=36, 2 abort at c=45, 3 PRESET at c=36 then start at c=37.
  function automatic logic [20:0] expv(input int scen, input int c);
    logic [8:0] s;
    logic       b, d, k;
    logic [7:0] r;
    case (c)
      0:       s = 9'b10000_1000;
      10, 70:  s = 9'b01000_0000;
      40:      s = 9'b00100_0000;
      30, 60:  s = 9'b00010_0100;
      90:      s = 9'b00001_0001;
      130:     s = 9'b00010_0010;
      default: s = 9'b00000_0000;
    endcase
    b = (c < 130);
    d = (c == 130);
    k = 1'b0;
    r = (c < 40) ? 8'd0 : (c < 70) ? 8'd1 : 8'd2;
    if (scen == 1 && c >= 36) begin
      s = (c == 36) ? 9'b00000_0010 : (c == 37) ? 9'b00001_0001 :
          (c == 77) ? 9'b00010_0010 : 9'b00000_0000;
      b = (c < 77);
      d = (c == 77);
      k = 1'b1;
      r = 8'd0;
    end
    if (scen == 2 && c >= 45) begin
      s = (c == 45) ? 9'b00010_0010 : 9'b00000_0000;
      b = 1'b0;
      d = 1'b0;
      r = 8'd1;
    end
    if (scen == 3 && c >= 36) begin
      s = (c == 37) ? 9'b10000_1000 : 9'b00000_0000;
      b = (c >= 37);
      d = 1'b0;
      r = 8'd0;
    end
    return {s, b, d, 1'b0, k, r};
  endfunction

  task automatic default_cfg();
    rows = 8'd3; x_periods = 16'd2; y_periods = 16'd1; ret_periods = 16'd4;
    stop_y = 2'b11; start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_scan(input int scen, input int ncyc, input bit noise, input string name);
    logic [20:0] e;
    default_cfg();
    start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    // Reconfiguring while busy must not disturb the captured scan.
    if (noise) x_periods = 16'd7;
    for (int c = 0; c <= ncyc; c++) begin
      e = expv(scen, c);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s c=%0d got=%b required=%b", name, c, obs, e);
      end
      start  = (noise && (c == 20 || c == 65)) ? 1'b1 : 1'b0;
      stop_y = (scen == 1 && c == 35) ? 2'b10 : 2'b11;
      abort  = (scen == 2 && c == 44) ? 1'b1 : 1'b0;
      if (scen == 3 && c == 35) PRESET = 1'b1;
      if (scen == 3 && c == 36) begin
        PRESET = 1'b0;
        start  = 1'b1;
      end
      @(posedge PCLK); #1;
    end
    start = 1'b0; abort = 1'b0; stop_y = 2'b11; x_periods = 16'd2;
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    default_cfg();
    apply_reset();
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL reset got=%b required=%b", obs, 21'd0);
    end
  endtask

  task automatic test_err(input logic [7:0] r, input logic [15:0] xp, input string name);
    default_cfg();
    rows = r; x_periods = xp;
    start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    checks++;
    if (obs !== 21'b00000_0000_0010_00000000) begin
      failures++;
      $display("FAIL %s pulse got=%b required=%b", name, obs, 21'b00000_0000_0010_00000000);
    end
    @(posedge PCLK); #1;
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL %s after got=%b required=%b", name, obs, 21'd0);
    end
    default_cfg();
  endtask

  task automatic test_normal();
    run_scan(0, 135, 1'b0, "normal");
  endtask

  task automatic test_kill();
    run_scan(1, 82, 1'b0, "kill");
  endtask

  task automatic test_abort();
    run_scan(2, 50, 1'b0, "abort");
    run_scan(0, 135, 1'b0, "after_abort");
  endtask

  task automatic test_preset();
    run_scan(3, 40, 1'b0, "preset");
    apply_reset();
  endtask

  task automatic test_back_to_back();
    default_cfg();
    abort = 1'b1;
    @(posedge PCLK); #1;
    abort = 1'b0;
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL idle_abort got=%b required=%b", obs, 21'd0);
    end
    run_scan(0, 135, 1'b1, "noisy");
  endtask

  initial begin
    PRESET = 1'b1;
    default_cfg();
    test_reset();
    test_err(8'd0, 16'd2, "err_rows0");
    test_err(8'd3, 16'd0, "err_x0");
    test_normal();
    test_kill();
    test_abort();
    test_preset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
